parity_stream_sched: RTL and testbench

Shared parity-engine scheduler. Arbitrates two word requesters round-robin onto one serial parity-tracking engine. Shifts the granted word LSB-first through the four-state even/odd zeros/ones FSM. Returns the final one-hot parity state, the ones count and the requester ID over a valid/ready result port. Sits between requester datapaths and any consumer needing per-word 0/1 parity classification.

---
 rtl/parity_stream_sched_if.sv | 40 ++++
 rtl/parity_stream_sched.sv | 115 +++++++++++
 tb/tb_parity_stream_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_stream_sched_if.sv
// Requester, result and status bundle for parity_stream_sched.
// slave: scheduler side; master: requesters/consumer side.
interface parity_stream_sched_if #(
  parameter int W = 8
);
  localparam int CW = $clog2(W + 1);

  logic          req0_valid;
  logic [W-1:0]  req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [W-1:0]  req1_data;
  logic          req1_ready;
  logic          res_valid;
  logic          res_ready;
  logic          res_id;
  logic [3:0]    res_state;
  logic [CW-1:0] res_ones;
  logic          busy;

  modport slave (
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready,
    output res_valid,
    input  res_ready,
    output res_id, res_state, res_ones, busy
  );

  modport master (
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready,
    input  res_valid,
    output res_ready,
    input  res_id, res_state, res_ones, busy
  );
endinterface

// File: rtl/parity_stream_sched.sv
// Round-robin scheduler of two word requesters onto one serial
// parity engine; ports: clk, reset (async high), io (slave bundle).
module parity_stream_sched #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  parity_stream_sched_if.slave  io
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        st_q, st_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [3:0]    par_q, par_d;
  logic [3:0]    par_nx;
  logic          id_q, id_d;
  logic          last_q, last_d;
  logic          g0, g1;
  logic          acc0, acc1;
  logic          bit_i;

  // last_q is the requester granted most recently; a tie goes
  // to the other one. Reset value 1 lets req0 win the first tie.
  assign g0 = io.req0_valid && (!io.req1_valid || last_q);
  assign g1 = io.req1_valid && (!io.req0_valid || !last_q);

  assign io.req0_ready = (st_q == IDLE) && g0 && !reset;
  assign io.req1_ready = (st_q == IDLE) && g1 && !reset;

  assign acc0 = io.req0_valid && io.req0_ready;
  assign acc1 = io.req1_valid && io.req1_ready;

  assign bit_i = sh_q[0];

  always_comb begin
    par_nx = 4'b1000;
    unique case (par_q)
      4'b1000: par_nx = bit_i ? 4'b0100 : 4'b0010;
      4'b0100: par_nx = bit_i ? 4'b1000 : 4'b0001;
      4'b0010: par_nx = bit_i ? 4'b0001 : 4'b1000;
      4'b0001: par_nx = bit_i ? 4'b0010 : 4'b0100;
      default: par_nx = 4'b1000;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    ones_d = ones_q;
    par_d  = par_q;
    id_d   = id_q;
    last_d = last_q;
    unique case (st_q)
      IDLE: begin
        if (acc0 || acc1) begin
          sh_d   = acc1 ? io.req1_data : io.req0_data;
          cnt_d  = '0;
          ones_d = '0;
          par_d  = 4'b1000;
          id_d   = acc1;
          last_d = acc1;
          st_d   = SHIFT;
        end
      end
      SHIFT: begin
        sh_d   = sh_q >> 1;
        par_d  = par_nx;
        ones_d = ones_q + CW'(bit_i);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1))
          st_d = DONE;
      end
      DONE: begin
        if (io.res_ready)
          st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      sh_q   <= '0;
      cnt_q  <= '0;
      ones_q <= '0;
      par_q  <= 4'b1000;
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
      par_q  <= par_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign io.res_valid = (st_q == DONE);
  assign io.busy      = (st_q != IDLE);
  assign io.res_state = par_q;
  assign io.res_ones  = ones_q;
  assign io.res_id    = id_q;
endmodule

// File: tb/tb_parity_stream_sched.sv
// Directed self-checking bench for parity_stream_sched,
// covering W=8 and W=7 instances.
module tb_parity_stream_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  parity_stream_sched_if #(.W(8)) i8 ();
  parity_stream_sched_if #(.W(7)) i7 ();

  parity_stream_sched #(.W(8)) u8 (
    .clk   (clk),
    .reset (reset),
    .io    (i8.slave)
  );

  parity_stream_sched #(.W(7)) u7 (
    .clk   (clk),
    .reset (reset),
    .io    (i7.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input bit id, input logic [7:0] d,
                       input logic [3:0] es, input int eo);
    int n;
    logic rdy;
    i8.res_ready = 1'b1;
    if (id) begin
      i8.req1_valid = 1'b1;
      i8.req1_data  = d;
    end else begin
      i8.req0_valid = 1'b1;
      i8.req0_data  = d;
    end
    #1;
    n = 0;
    rdy = id ? i8.req1_ready : i8.req0_ready;
    while (!rdy && n < 20) begin
      step();
      n++;
      rdy = id ? i8.req1_ready : i8.req0_ready;
    end
    chk("w8_ready", {31'd0, rdy}, 1);
    step();
    i8.req0_valid = 1'b0;
    i8.req1_valid = 1'b0;
    i8.req0_data  = ~d;
    i8.req1_data  = ~d;
    #1;
    chk("w8_ready_pulse", {30'd0, i8.req1_ready, i8.req0_ready}, 0);
    n = 0;
    while (!i8.res_valid && n < 40) begin
      step();
      n++;
    end
    chk("w8_latency", n, 8);
    chk("w8_state", {28'd0, i8.res_state}, {28'd0, es});
    chk("w8_ones", {28'd0, i8.res_ones}, eo);
    chk("w8_id", {31'd0, i8.res_id}, {31'd0, id});
    step();
    chk("w8_done_clr", {30'd0, i8.res_valid, i8.busy}, 0);
  endtask

  task automatic send7(input logic [6:0] d,
                       input logic [3:0] es, input int eo);
    int n;
    i7.res_ready  = 1'b1;
    i7.req0_valid = 1'b1;
    i7.req0_data  = d;
    #1;
    chk("w7_ready", {31'd0, i7.req0_ready}, 1);
    step();
    i7.req0_valid = 1'b0;
    i7.req0_data  = ~d;
    n = 0;
    while (!i7.res_valid && n < 40) begin
      step();
      n++;
    end
    chk("w7_latency", n, 7);
    chk("w7_state", {28'd0, i7.res_state}, {28'd0, es});
    chk("w7_ones", {29'd0, i7.res_ones}, eo);
    step();
    chk("w7_done_clr", {31'd0, i7.res_valid}, 0);
  endtask

  initial begin
    int n;
    int seen;
    bit g;
    i8.req0_valid = 1'b1;
    i8.req0_data  = 8'hA5;
    i8.req1_valid = 1'b0;
    i8.req1_data  = 8'h00;
    i8.res_ready  = 1'b1;
    i7.req0_valid = 1'b0;
    i7.req0_data  = 7'h00;
    i7.req1_valid = 1'b0;
    i7.req1_data  = 7'h00;
    i7.res_ready  = 1'b1;

    step();
    step();
    chk("rst_valid", {31'd0, i8.res_valid}, 0);
    chk("rst_state", {28'd0, i8.res_state}, 4'b1000);
    chk("rst_ones", {28'd0, i8.res_ones}, 0);
    chk("rst_id", {31'd0, i8.res_id}, 0);
    chk("rst_busy", {31'd0, i8.busy}, 0);
    chk("rst_ready", {30'd0, i8.req1_ready, i8.req0_ready}, 0);
    reset = 1'b0;
    #1;

    send8(1'b0, 8'hA5, 4'b1000, 4);
    send8(1'b1, 8'h01, 4'b0001, 1);
    send8(1'b1, 8'h00, 4'b1000, 0);

    send7(7'h01, 4'b0100, 1);
    send7(7'h00, 4'b0010, 0);

    // both requesters valid: expect strict alternation 0,1,0,1
    i8.res_ready  = 1'b1;
    i8.req0_valid = 1'b1;
    i8.req0_data  = 8'h07;
    i8.req1_valid = 1'b1;
    i8.req1_data  = 8'h03;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(i8.req0_ready || i8.req1_ready) && n < 30) begin
        step();
        n++;
      end
      chk("rr_both", {31'd0, i8.req0_ready && i8.req1_ready}, 0);
      g = i8.req1_ready;
      chk("rr_order", {31'd0, g}, k % 2);
      step();
      n = 0;
      while (!i8.res_valid && n < 40) begin
        step();
        n++;
      end
      chk("rr_no_ready_done",
          {30'd0, i8.req1_ready, i8.req0_ready}, 0);
      chk("rr_id", {31'd0, i8.res_id}, k % 2);
      chk("rr_ones", {28'd0, i8.res_ones}, (k % 2) ? 2 : 3);
      chk("rr_state", {28'd0, i8.res_state},
          (k % 2) ? 4'b1000 : 4'b0001);
      step();
    end
    i8.req0_valid = 1'b0;
    i8.req1_valid = 1'b0;
    n = 0;
    while (i8.busy && n < 20) begin
      step();
      n++;
    end

    // back-pressure in DONE with a second req0 word pending
    i8.res_ready  = 1'b0;
    i8.req0_valid = 1'b1;
    i8.req0_data  = 8'hFE;
    #1;
    chk("bp_ready", {31'd0, i8.req0_ready}, 1);
    step();
    i8.req0_data = 8'h00;
    n = 0;
    while (!i8.res_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_latency", n, 8);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold",
          {23'd0, i8.res_valid, i8.res_state, i8.res_ones},
          {23'd0, 1'b1, 4'b0001, 4'd7});
      chk("bp_no_ready", {31'd0, i8.req0_ready}, 0);
    end
    i8.res_ready = 1'b1;
    step();
    chk("bp_hs_valid", {31'd0, i8.res_valid}, 0);
    chk("bp_next_ready", {31'd0, i8.req0_ready}, 1);
    step();
    i8.req0_valid = 1'b0;
    n = 0;
    while (!i8.res_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_next_state", {28'd0, i8.res_state}, 4'b1000);
    chk("bp_next_ones", {28'd0, i8.res_ones}, 0);
    step();

    // reset three cycles into SHIFT drops the word
    i8.req1_valid = 1'b1;
    i8.req1_data  = 8'hFF;
    #1;
    chk("mr_ready", {31'd0, i8.req1_ready}, 1);
    step();
    i8.req1_valid = 1'b0;
    step();
    step();
    step();
    chk("mr_busy", {31'd0, i8.busy}, 1);
    reset = 1'b1;
    #1;
    chk("mr_rst_out",
        {22'd0, i8.res_valid, i8.busy, i8.res_id,
         i8.res_state, i8.res_ones},
        {22'd0, 1'b0, 1'b0, 1'b0, 4'b1000, 4'd0});
    step();
    step();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (i8.res_valid || i8.busy) seen++;
    end
    chk("mr_no_result", seen, 0);
    send8(1'b1, 8'h01, 4'b0001, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
